// File: rtl/cache_set_assoc.sv
// cache_set_assoc: write-back, write-allocate, set-associative byte cache with
// per-set age-ordered LRU replacement and a single-line memory port.
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   cpu_req/we/addr/wdata: byte request, accepted only while cpu_ready=1
//   cpu_ready            : controller idle
//   cpu_done/rdata/hit   : one-cycle completion pulse with read byte and hit flag
//   mem_req/we/addr/wdata: line transfer request (we=1 writeback, we=0 fill)
//   mem_rdata/mem_ready  : fill line and one-cycle transfer acknowledge
// Optional build macro CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_set_assoc #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned NUM_SETS    = 4,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned BLOCK_BYTES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [7:0]               cpu_wdata,
    output logic                     cpu_ready,
    output logic                     cpu_done,
    output logic [7:0]               cpu_rdata,
    output logic                     hit,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BLOCK_BYTES*8-1:0] mem_wdata,
    input  logic [BLOCK_BYTES*8-1:0] mem_rdata,
    input  logic                     mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
`endif
);

    localparam int unsigned OFF_W    = $clog2(BLOCK_BYTES);
    localparam int unsigned IDX_BITS = $clog2(NUM_SETS);
    localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int unsigned TAG_W    = ADDR_W - OFF_W - IDX_BITS;
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned LINE_W   = BLOCK_BYTES * 8;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BLOCK_BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_MASK  = IDX_W'(NUM_SETS - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_REFILL    = 2'd2;
    localparam logic [1:0] S_RESP      = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              ready_q, ready_d, done_q, done_d, hit_q, hit_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_we_q, req_we_d;
    logic [7:0]        req_wdata_q, req_wdata_d;
    logic [WAY_W-1:0]  vic_q, vic_d;

    logic              valid_q [NUM_SETS][WAYS];
    logic              valid_d [NUM_SETS][WAYS];
    logic              dirty_q [NUM_SETS][WAYS];
    logic              dirty_d [NUM_SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [NUM_SETS][WAYS];
    logic [WAY_W-1:0]  age_d   [NUM_SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [NUM_SETS][WAYS];
    logic [LINE_W-1:0] data_q  [NUM_SETS][WAYS];
    logic [LINE_W-1:0] data_d  [NUM_SETS][WAYS];

    // Address fields of the incoming request and of the latched miss request.
    logic [OFF_W-1:0] in_off, req_off;
    logic [IDX_W-1:0] in_idx, req_idx;
    logic [TAG_W-1:0] in_tag, req_tag;
    assign in_off  = OFF_W'(cpu_addr);
    assign in_idx  = IDX_W'(cpu_addr >> OFF_W) & IDX_MASK;
    assign in_tag  = TAG_W'(cpu_addr >> (OFF_W + IDX_BITS));
    assign req_off = OFF_W'(req_addr_q);
    assign req_idx = IDX_W'(req_addr_q >> OFF_W) & IDX_MASK;
    assign req_tag = TAG_W'(req_addr_q >> (OFF_W + IDX_BITS));

    // Tag compare and victim choice: lowest invalid way first, else the oldest way.
    logic             hit_c, found_c;
    logic [WAY_W-1:0] hit_way_c, vic_c;
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        found_c   = 1'b0;
        vic_c     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[in_idx][w] && (tag_q[in_idx][w] == in_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_q[in_idx][w] && !found_c) begin
                found_c = 1'b1;
                vic_c   = WAY_W'(w);
            end
        end
        if (!found_c) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[in_idx][w] == WAY_W'(WAYS - 1)) vic_c = WAY_W'(w);
            end
        end
    end

    logic             touch_en;
    logic [IDX_W-1:0] touch_set;
    logic [WAY_W-1:0] touch_way;

    // Controller next state, outputs and array updates.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        vic_d       = vic_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        touch_en    = 1'b0;
        touch_set   = in_idx;
        touch_way   = hit_way_c;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    if (hit_c) begin
                        done_d   = 1'b1;
                        hit_d    = 1'b1;
                        rdata_d  = data_q[in_idx][hit_way_c][{in_off, 3'b000} +: 8];
                        touch_en = 1'b1;
                        if (cpu_we) begin
                            data_d[in_idx][hit_way_c][{in_off, 3'b000} +: 8] = cpu_wdata;
                            dirty_d[in_idx][hit_way_c] = 1'b1;
                        end
                    end else begin
                        req_addr_d  = cpu_addr;
                        req_we_d    = cpu_we;
                        req_wdata_d = cpu_wdata;
                        vic_d       = vic_c;
                        mem_req_d   = 1'b1;
                        if (valid_q[in_idx][vic_c] && dirty_q[in_idx][vic_c]) begin
                            state_d     = S_WRITEBACK;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = (ADDR_W'(tag_q[in_idx][vic_c]) << (OFF_W + IDX_BITS))
                                        | (ADDR_W'(in_idx) << OFF_W);
                            mem_wdata_d = data_q[in_idx][vic_c];
                        end else begin
                            state_d    = S_REFILL;
                            mem_we_d   = 1'b0;
                            mem_addr_d = cpu_addr & LINE_MASK;
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ready) begin
                    state_d    = S_REFILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = req_addr_q & LINE_MASK;
                end
            end
            S_REFILL: begin
                if (mem_ready) begin
                    state_d                 = S_RESP;
                    mem_req_d               = 1'b0;
                    valid_d[req_idx][vic_q] = 1'b1;
                    dirty_d[req_idx][vic_q] = 1'b0;
                    tag_d[req_idx][vic_q]   = req_tag;
                    data_d[req_idx][vic_q]  = mem_rdata;
                    touch_en                = 1'b1;
                    touch_set               = req_idx;
                    touch_way               = vic_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                rdata_d = data_q[req_idx][vic_q][{req_off, 3'b000} +: 8];
                if (req_we_q) begin
                    data_d[req_idx][vic_q][{req_off, 3'b000} +: 8] = req_wdata_q;
                    dirty_d[req_idx][vic_q] = 1'b1;
                end
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // Age update: touched way becomes 0 (MRU); ways younger than it age by one.
    always_comb begin
        age_d = age_q;
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age_d[touch_set][w] = '0;
                end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                    age_d[touch_set][w] = age_q[touch_set][w] + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            vic_q       <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    // Ages restart as a permutation so the ordering stays total.
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            vic_q       <= vic_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            age_q       <= age_d;
        end
    end

    // Tag and data payload need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign cpu_ready = ready_q;
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
    assign hit       = hit_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    // Saturating counters of completed accesses.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (done_d) begin
            if (hit_d) begin
                if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
